// File: rtl/mbinit_sb_arbiter.sv
// mbinit_sb_arbiter
//   Shares the single sideband TX path between the six MBINIT substate engines
//   (0=PARAM, 1=CAL, 2=REPAIRCLK, 3=REPAIRVAL, 4=REVERSALMB, 5=REPAIRMB).
//   Requests are served round-robin, one message at a time; after the message is
//   accepted by the sideband TX the arbiter waits for the partner response and
//   flags a timeout if none arrives within TIMEOUT_CYC cycles.
//
// Ports
//   CLK, rst          clock, synchronous active-high reset
//   i_flush           abort current transaction (MBINIT exit), keeps ptr/timeout_src
//   i_req             per-requester level request, held until grant
//   i_msg_id/_data    flattened per-requester message ID / payload
//   o_grant           one-hot pulse: message of requester i was sent
//   o_sb_valid/_msg_id/_data/_src   sideband TX message and its requester
//   i_sb_ready        sideband TX handshake
//   i_sb_rsp_valid    partner response for the in-flight message
//   o_rsp_done        one-hot pulse: response arrived for requester i
//   o_timeout/_src    timeout pulse and requester index (index held)
//   o_busy            arbiter not idle
//
// state    | meaning
// IDLE     | no message latched; picks next requester round-robin
// SEND     | message presented on sideband TX, waiting for i_sb_ready
// WAIT_RSP | message sent, counting cycles until partner response

module mbinit_sb_arbiter #(
  parameter int N_REQ       = 6,
  parameter int MSG_W       = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 800000,
  parameter int CNT_W       = 20
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*MSG_W-1:0]    i_msg_id,
  input  logic [N_REQ*DATA_W-1:0]   i_msg_data,
  output logic [N_REQ-1:0]          o_grant,
  output logic                      o_sb_valid,
  output logic [MSG_W-1:0]          o_sb_msg_id,
  output logic [DATA_W-1:0]         o_sb_data,
  output logic [2:0]                o_sb_src,
  input  logic                      i_sb_ready,
  input  logic                      i_sb_rsp_valid,
  output logic [N_REQ-1:0]          o_rsp_done,
  output logic                      o_timeout,
  output logic [2:0]                o_timeout_src,
  output logic                      o_busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  localparam logic [2:0]       LAST_IDX = 3'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  logic [1:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic             pick_found;
  logic [2:0]       pick_idx;
  logic [N_REQ-1:0] src_onehot;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned idx;
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    idx        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && i_req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx[2:0];
      end
    end
  end

  assign src_onehot = ONE_HOT0 << o_sb_src;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      cnt           <= '0;
      o_grant       <= '0;
      o_sb_valid    <= 1'b0;
      o_sb_msg_id   <= '0;
      o_sb_data     <= '0;
      o_sb_src      <= 3'd0;
      o_rsp_done    <= '0;
      o_timeout     <= 1'b0;
      o_timeout_src <= 3'd0;
      o_busy        <= 1'b0;
    end else begin
      o_grant    <= '0;
      o_rsp_done <= '0;
      o_timeout  <= 1'b0;
      if (i_flush) begin
        // Abort wins over any handshake/response/timeout in the same cycle.
        state      <= IDLE;
        o_sb_valid <= 1'b0;
        cnt        <= '0;
        o_busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pick_found) begin
              o_sb_msg_id <= i_msg_id[pick_idx*MSG_W +: MSG_W];
              o_sb_data   <= i_msg_data[pick_idx*DATA_W +: DATA_W];
              o_sb_src    <= pick_idx;
              o_sb_valid  <= 1'b1;
              o_busy      <= 1'b1;
              state       <= SEND;
            end
          end
          SEND: begin
            // The latched message goes out even if the request was dropped.
            if (i_sb_ready) begin
              o_sb_valid <= 1'b0;
              o_grant    <= src_onehot;
              ptr        <= (o_sb_src == LAST_IDX) ? 3'd0 : o_sb_src + 3'd1;
              cnt        <= '0;
              state      <= WAIT_RSP;
            end
          end
          WAIT_RSP: begin
            cnt <= cnt + CNT_W'(1);
            if (i_sb_rsp_valid) begin
              o_rsp_done <= src_onehot;
              o_busy     <= 1'b0;
              state      <= IDLE;
            end else if (cnt == CNT_TC) begin
              o_timeout     <= 1'b1;
              o_timeout_src <= o_sb_src;
              o_busy        <= 1'b0;
              state         <= IDLE;
            end
          end
          default: begin
            state      <= IDLE;
            o_sb_valid <= 1'b0;
            o_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mbinit_sb_arbiter.sv
module tb_mbinit_sb_arbiter;

  localparam int N  = 6;
  localparam int MW = 8;
  localparam int DW = 16;
  localparam int TO = 16;
  localparam int CW = 5;

  logic            CLK = 1'b0;
  logic            rst;
  logic            i_flush;
  logic [N-1:0]    i_req;
  logic [N*MW-1:0] i_msg_id;
  logic [N*DW-1:0] i_msg_data;
  logic [N-1:0]    o_grant;
  logic            o_sb_valid;
  logic [MW-1:0]   o_sb_msg_id;
  logic [DW-1:0]   o_sb_data;
  logic [2:0]      o_sb_src;
  logic            i_sb_ready;
  logic            i_sb_rsp_valid;
  logic [N-1:0]    o_rsp_done;
  logic            o_timeout;
  logic [2:0]      o_timeout_src;
  logic            o_busy;

  int checks = 0;
  int errors = 0;

  mbinit_sb_arbiter #(
    .N_REQ(N), .MSG_W(MW), .DATA_W(DW), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .rst(rst), .i_flush(i_flush), .i_req(i_req),
    .i_msg_id(i_msg_id), .i_msg_data(i_msg_data), .o_grant(o_grant),
    .o_sb_valid(o_sb_valid), .o_sb_msg_id(o_sb_msg_id), .o_sb_data(o_sb_data),
    .o_sb_src(o_sb_src), .i_sb_ready(i_sb_ready), .i_sb_rsp_valid(i_sb_rsp_valid),
    .o_rsp_done(o_rsp_done), .o_timeout(o_timeout), .o_timeout_src(o_timeout_src),
    .o_busy(o_busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_flush = 1'b0; i_req = '0; i_sb_ready = 1'b0; i_sb_rsp_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      i_msg_id[i*MW +: MW]   = 8'(8'h10 + i);
      i_msg_data[i*DW +: DW] = 16'(16'hD000 + i);
    end
    i_msg_id[2*MW +: MW]   = 8'h5A;
    i_msg_data[2*DW +: DW] = 16'hBEEF;
    tick; tick;
    rst = 1'b0;
    checks++;
    if ({o_grant, o_sb_valid, o_sb_msg_id, o_sb_data, o_sb_src, o_rsp_done, o_timeout, o_timeout_src, o_busy} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b grant=%b busy=%b id=%h required all zero", o_sb_valid, o_grant, o_busy, o_sb_id_dummy());
    end
  endtask

  function automatic logic [MW-1:0] o_sb_id_dummy();
    return o_sb_msg_id;
  endfunction

  task automatic test_single;
    i_req = 6'b000100; i_sb_ready = 1'b1;
    tick;
    checks++;
    if ({o_sb_valid, o_sb_msg_id, o_sb_data, o_sb_src, o_busy, o_grant} !== {1'b1, 8'h5A, 16'hBEEF, 3'd2, 1'b1, 6'b0}) begin
      errors++; $display("FAIL single_send: valid=%b id=%h data=%h src=%0d grant=%b required 1 5a beef 2 000000", o_sb_valid, o_sb_msg_id, o_sb_data, o_sb_src, o_grant);
    end
    i_req = '0;
    tick;
    checks++;
    if ({o_grant, o_sb_valid} !== {6'b000100, 1'b0}) begin
      errors++; $display("FAIL single_grant: grant=%b valid=%b required 000100 0", o_grant, o_sb_valid);
    end
    tick; tick;
    checks++;
    if ({o_grant, o_rsp_done} !== 12'b0) begin
      errors++; $display("FAIL single_quiet: grant=%b done=%b required zero", o_grant, o_rsp_done);
    end
    i_sb_rsp_valid = 1'b1;
    tick;
    i_sb_rsp_valid = 1'b0;
    checks++;
    if ({o_rsp_done, o_busy, o_timeout} !== {6'b000100, 1'b0, 1'b0}) begin
      errors++; $display("FAIL single_done: done=%b busy=%b timeout=%b required 000100 0 0", o_rsp_done, o_busy, o_timeout);
    end
  endtask

  task automatic test_fairness;
    logic [N-1:0] exp_g;
    int wait_n;
    rst = 1'b1; tick; rst = 1'b0;
    i_req = '1; i_sb_ready = 1'b1; i_sb_rsp_valid = 1'b1;
    for (int g = 0; g < 7; g++) begin
      exp_g  = 6'b000001 << (g % N);
      wait_n = 0;
      tick;
      while (o_grant == '0 && wait_n < 10) begin
        checks++;
        if ($countones({o_grant, o_rsp_done, o_timeout}) > 1) begin
          errors++; $display("FAIL fair_exclusive: grant=%b done=%b timeout=%b", o_grant, o_rsp_done, o_timeout);
        end
        tick; wait_n++;
      end
      checks++;
      if (o_grant !== exp_g) begin
        errors++; $display("FAIL fair_order_%0d: grant=%b required %b", g, o_grant, exp_g);
      end
    end
    i_req = '0;
    tick;
    i_sb_rsp_valid = 1'b0;
    tick; tick;
  endtask

  task automatic test_backpressure;
    i_req = 6'b001000; i_sb_ready = 1'b0;
    tick;
    i_req = '0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({o_sb_valid, o_sb_msg_id, o_sb_data, o_sb_src, o_grant} !== {1'b1, 8'h13, 16'hD003, 3'd3, 6'b0}) begin
        errors++; $display("FAIL bp_stable_%0d: valid=%b id=%h data=%h src=%0d grant=%b required 1 13 d003 3 000000", c, o_sb_valid, o_sb_msg_id, o_sb_data, o_sb_src, o_grant);
      end
      tick;
    end
    i_sb_ready = 1'b1;
    tick;
    checks++;
    if ({o_grant, o_sb_valid} !== {6'b001000, 1'b0}) begin
      errors++; $display("FAIL bp_grant: grant=%b valid=%b required 001000 0", o_grant, o_sb_valid);
    end
    i_sb_rsp_valid = 1'b1;
    tick;
    i_sb_rsp_valid = 1'b0;
    checks++;
    if (o_rsp_done !== 6'b001000) begin
      errors++; $display("FAIL bp_done: done=%b required 001000", o_rsp_done);
    end
  endtask

  task automatic test_timeout;
    // ptr=4 after the backpressure test
    i_req = 6'b010000; i_sb_ready = 1'b1;
    tick;
    i_req = '0;
    tick;
    for (int k = 1; k < TO; k++) begin
      tick;
      checks++;
      if (o_timeout !== 1'b0) begin
        errors++; $display("FAIL to_early_%0d: timeout=%b required 0", k, o_timeout);
      end
    end
    tick;
    checks++;
    if ({o_timeout, o_timeout_src, o_busy, o_rsp_done} !== {1'b1, 3'd4, 1'b0, 6'b0}) begin
      errors++; $display("FAIL to_pulse: timeout=%b src=%0d busy=%b done=%b required 1 4 0 000000", o_timeout, o_timeout_src, o_busy, o_rsp_done);
    end
    tick;
    checks++;
    if ({o_timeout, o_timeout_src} !== {1'b0, 3'd4}) begin
      errors++; $display("FAIL to_hold: timeout=%b src=%0d required 0 4", o_timeout, o_timeout_src);
    end
    // ptr=5 -> requester 1 is next; response lands on the final count
    i_req = 6'b000010;
    tick;
    i_req = '0;
    tick;
    for (int k = 1; k < TO; k++) tick;
    i_sb_rsp_valid = 1'b1;
    tick;
    i_sb_rsp_valid = 1'b0;
    checks++;
    if ({o_rsp_done, o_timeout, o_timeout_src} !== {6'b000010, 1'b0, 3'd4}) begin
      errors++; $display("FAIL to_rsp_wins: done=%b timeout=%b src=%0d required 000010 0 4", o_rsp_done, o_timeout, o_timeout_src);
    end
  endtask

  task automatic test_flush_reset;
    // ptr=2 here
    i_req = 6'b100000; i_sb_ready = 1'b0;
    tick;
    i_req = '0; i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    checks++;
    if ({o_sb_valid, o_busy, o_grant, o_rsp_done, o_timeout} !== '0) begin
      errors++; $display("FAIL flush_send: valid=%b busy=%b grant=%b done=%b timeout=%b required zero", o_sb_valid, o_busy, o_grant, o_rsp_done, o_timeout);
    end
    i_req = 6'b001001;
    tick;
    i_req = '0;
    checks++;
    if ({o_sb_valid, o_sb_src} !== {1'b1, 3'd3}) begin
      errors++; $display("FAIL flush_ptr_kept: valid=%b src=%0d required 1 3", o_sb_valid, o_sb_src);
    end
    i_sb_ready = 1'b1;
    tick;
    i_flush = 1'b1; i_sb_rsp_valid = 1'b1;
    tick;
    i_flush = 1'b0; i_sb_rsp_valid = 1'b0;
    checks++;
    if ({o_busy, o_grant, o_rsp_done, o_timeout, o_timeout_src} !== {1'b0, 6'b0, 6'b0, 1'b0, 3'd4}) begin
      errors++; $display("FAIL flush_wait: busy=%b grant=%b done=%b timeout=%b tsrc=%0d required 0 0 0 0 4", o_busy, o_grant, o_rsp_done, o_timeout, o_timeout_src);
    end
    for (int k = 0; k < TO + 4; k++) begin
      tick;
      checks++;
      if ({o_timeout, o_rsp_done, o_busy} !== '0) begin
        errors++; $display("FAIL flush_no_late_%0d: timeout=%b done=%b busy=%b required zero", k, o_timeout, o_rsp_done, o_busy);
      end
    end
    // ptr=4 after sending requester 3
    i_req = 6'b100001;
    tick;
    i_req = '0;
    checks++;
    if (o_sb_src !== 3'd5) begin
      errors++; $display("FAIL flush_ptr_adv: src=%0d required 5", o_sb_src);
    end
    tick;
    i_sb_rsp_valid = 1'b1;
    tick;
    i_sb_rsp_valid = 1'b0;
    // ptr=0; serve requester 1 so ptr becomes 2, then reset mid-wait
    i_req = 6'b000010;
    tick;
    i_req = '0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({o_grant, o_sb_valid, o_sb_msg_id, o_sb_data, o_sb_src, o_rsp_done, o_timeout, o_timeout_src, o_busy} !== '0) begin
      errors++; $display("FAIL rst_wait: valid=%b busy=%b src=%0d tsrc=%0d id=%h required all zero", o_sb_valid, o_busy, o_sb_src, o_timeout_src, o_sb_msg_id);
    end
    i_req = 6'b000101;
    tick;
    i_req = '0;
    checks++;
    if ({o_sb_valid, o_sb_src, o_sb_msg_id} !== {1'b1, 3'd0, 8'h10}) begin
      errors++; $display("FAIL rst_ptr_zero: valid=%b src=%0d id=%h required 1 0 10", o_sb_valid, o_sb_src, o_sb_msg_id);
    end
    tick;
    checks++;
    if (o_grant !== 6'b000001) begin
      errors++; $display("FAIL rst_after_grant: grant=%b required 000001", o_grant);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_timeout;
    test_flush_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
